// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU operation codes and datapath mux selects, plus the bundled control word.
// Pure declarations; no logic, no latency, no flow control.
package mips_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Control FSM states; encodings 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_e;

    // alu_op codes, shared with the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Bundled datapath control word
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction plus one cycle per mem_ready-low memory cycle.
// Backpressure: mem_ready low holds FETCH/MEMREAD/MEMWRITE with the access strobes asserted.
//
// Ports: clk, rst_n (async active-low); opcode (instr[31:26]); mem_ready (memory
// handshake); datapath controls pc_write..pc_source; illegal_op (one-cycle flag);
// state (current FSM state, debug).
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Opcode is re-sampled here; anything but LW/SW abandons the access
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Output decode: Moore except ir_write/pc_write in FETCH and illegal_op
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR load and PC+4 commit only on the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = !op_is_legal(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // The state register resets to FETCH, whose decode asserts mem_read; gate the
    // whole word with rst_n so nothing reaches memory or the register file in reset.
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign i_or_d        = ctrl_gated.i_or_d;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign ir_write      = ctrl_gated.ir_write;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign reg_dst       = ctrl_gated.reg_dst;
    assign reg_write     = ctrl_gated.reg_write;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign alu_op        = ctrl_gated.alu_op;
    assign pc_source     = ctrl_gated.pc_source;
    assign illegal_op    = ctrl_gated.illegal_op;
    assign state         = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE and MEMADR.
REQ-005 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
REQ-007 alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-008 alu_op  out  2  feeds ALU control: 00 = add, 01 = sub, 10 = funct-decoded.
REQ-009 pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 illegal_op  out  1  one-cycle flag for an unrecognised opcode.
REQ-011 state  out  4  current state, for debug.

Function
REQ-012 The block SHALL be a Moore FSM; the only Mealy terms are ir_write and pc_write in FETCH (both = mem_ready) and illegal_op.
REQ-013 Outputs not listed for a state SHALL be 0.
REQ-014 Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
REQ-015 FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; holds until mem_ready=1, then goes to DECODE.
REQ-016 DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: LW/SW->MEMADR, R->EXECUTE, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX.
REQ-017 DECODE with any other opcode SHALL assert illegal_op for that cycle and go to FETCH.
REQ-018 MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMREAD, SW->MEMWRITE.
REQ-019 MEMREAD(3): mem_read=1, i_or_d=1; holds until mem_ready=1, then goes to MEMWB.
REQ-020 MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
REQ-021 MEMWRITE(5): mem_write=1, i_or_d=1; holds until mem_ready=1, then goes to FETCH.
REQ-022 EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
REQ-023 ALUWB(7): reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH.
REQ-024 BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
REQ-025 JUMP(9): pc_write=1, pc_source=10; then FETCH.
REQ-026 ADDIEX(10): alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
REQ-027 ADDIWB(11): reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH.
REQ-028 Encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-029 With mem_ready constantly high, cycle counts SHALL be: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
REQ-030 Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle.
REQ-031 During a stall, mem_read/mem_write and i_or_d SHALL stay asserted, and ir_write/pc_write SHALL stay 0.
REQ-032 mem_ready SHALL be ignored in states that make no memory access.

Reset
REQ-033 While rst_n=0: state = FETCH and every control output is forced to 0 (including mem_read), regardless of clk.
REQ-034 The first rising edge after rst_n deasserts SHALL begin a normal FETCH.
REQ-035 Reset asserted mid-instruction SHALL abandon that instruction with no write strobe (reg_write, mem_write, pc_write, pc_write_cond) emitted.

Structure
REQ-036 The shared package mips_pkg SHALL hold the opcode constants, state encodings, alu_op codes, alu_src_b codes and pc_source codes; ALU control uses the same alu_op constants.
REQ-037 The block SHALL be a single module (state register, next-state logic, output decode); no sub-module.

Verification
REQ-038 Reset: rst_n=0 mid-MEMREAD -> all outputs 0 and state=0 immediately; after release, FETCH with mem_read=1.
REQ-039 LW with mem_ready=1 -> states 0,1,2,3,4 in order; reg_write=1 only in cycle 5, with mem_to_reg=1.
REQ-040 SW with mem_ready low for 2 cycles in MEMWRITE -> mem_write high for 3 cycles; exactly one completion; back to FETCH.
REQ-041 R-type -> alu_op=10 in EXECUTE; ALUWB has reg_dst=1, reg_write=1.
REQ-042 BEQ -> pc_write_cond=1, alu_op=01, pc_source=01 in cycle 3; J -> pc_write=1, pc_source=10 in cycle 3.
REQ-043 opcode=111111 -> illegal_op=1 for one cycle in DECODE; next state FETCH; no write strobes.
